// File: rtl/outport_sched_pkg.sv
// Shared definitions for the output-port scheduler: mode and state
// encodings plus the index-width helper.
package outport_sched_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED       = 2'd0,
        MODE_RR          = 2'd1,
        MODE_FIRST_READY = 2'd2
    } mode_e;

    typedef enum logic {
        ST_SELECT = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Ceiling log2, never less than 1 so a port index always has a bit.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/port_rr_picker.sv
// Combinational circular search: returns the first eligible port at or
// after 'start', wrapping from NUM_PORTS-1 back to 0.
module port_rr_picker #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0] eligible,
    input  logic [IDX_WIDTH-1:0] start,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] index
);

    logic [IDX_WIDTH-1:0] idx;

    // Walk the ports in circular order and keep the first eligible one
    always_comb begin
        found = 1'b0;
        index = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = IDX_WIDTH'((32'(start) + i) % NUM_PORTS);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/outport_sel_scheduler.sv
// Per-packet output-port scheduler for the 4-port output aggregator.
// Chooses a port (fixed / round-robin / first-ready), locks it for the
// packet and releases it on eop.
// Optional feature macro: OUTPORT_SCHED_STATS_EN enables the per-port
// packet counters and cnt_clr; otherwise pkt_cnt reads zero.
module outport_sel_scheduler
    import outport_sched_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned NUM_PORTS_WIDTH = log2(NUM_PORTS),
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pkt_start,
    input  logic                           eop,
    input  logic [NUM_PORTS-1:0]           out_rdy,
    input  logic [NUM_PORTS-1:0]           port_en,
    input  logic [1:0]                     mode,
    input  logic [NUM_PORTS_WIDTH-1:0]     fixed_port,
    input  logic                           cnt_clr,
    output logic [NUM_PORTS_WIDTH-1:0]     outport_sel,
    output logic                           sel_valid,
    output logic                           busy,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_cnt
);

    state_e                     state;
    state_e                     state_next;
    logic [NUM_PORTS_WIDTH-1:0] rr_ptr;
    logic [NUM_PORTS_WIDTH-1:0] rr_start;
    logic [NUM_PORTS_WIDTH-1:0] pick_start;
    logic [NUM_PORTS_WIDTH-1:0] pick_idx;
    logic                       pick_found;
    logic [NUM_PORTS_WIDTH-1:0] cand_idx;
    logic                       cand_found;
    logic [NUM_PORTS-1:0]       eligible;
    logic [NUM_PORTS_WIDTH-1:0] sel_next;
    logic                       valid_next;
    logic                       pkt_done;

    assign eligible = port_en & out_rdy;
    assign pkt_done = (state == ST_LOCKED) && eop;

    // Round-robin search begins one past the last served port
    always_comb begin
        if (rr_ptr == NUM_PORTS_WIDTH'(NUM_PORTS - 1))
            rr_start = '0;
        else
            rr_start = rr_ptr + 1'b1;
        pick_start = (mode == MODE_RR) ? rr_start : '0;
    end

    port_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WIDTH (NUM_PORTS_WIDTH)
    ) u_picker (
        .eligible (eligible),
        .start    (pick_start),
        .found    (pick_found),
        .index    (pick_idx)
    );

    // Candidate per mode; the unused encoding behaves as FIXED
    always_comb begin
        case (mode)
            MODE_RR, MODE_FIRST_READY: begin
                cand_found = pick_found;
                cand_idx   = pick_idx;
            end
            default: begin
                cand_found = port_en[fixed_port];
                cand_idx   = fixed_port;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_SELECT;
        else
            state <= state_next;
    end

    // Next-state: lock only on an accepted start, unlock on eop
    always_comb begin
        state_next = state;
        case (state)
            ST_SELECT: if (pkt_start && sel_valid) state_next = ST_LOCKED;
            ST_LOCKED: if (eop)                    state_next = ST_SELECT;
            default:                               state_next = ST_SELECT;
        endcase
    end

    // Output next values; sel_valid drops on eop so the stale port is never
    // offered for a back-to-back start before a fresh candidate is registered
    always_comb begin
        sel_next   = outport_sel;
        valid_next = sel_valid;
        busy       = (state == ST_LOCKED);
        case (state)
            ST_SELECT: begin
                if (pkt_start && sel_valid) begin
                    sel_next   = outport_sel;
                    valid_next = 1'b1;
                end else if (cand_found) begin
                    sel_next   = cand_idx;
                    valid_next = 1'b1;
                end else begin
                    valid_next = 1'b0;
                end
            end
            ST_LOCKED: valid_next = !eop;
            default:   valid_next = 1'b0;
        endcase
    end

    // Selection and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            outport_sel <= '0;
            sel_valid   <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            outport_sel <= sel_next;
            sel_valid   <= valid_next;
            if (pkt_done)
                rr_ptr <= outport_sel;
        end
    end

`ifdef OUTPORT_SCHED_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];

    // Per-port packet counters; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++)
                cnt_q[i] <= '0;
        end else if (pkt_done) begin
            cnt_q[outport_sel] <= cnt_q[outport_sel] + CNT_WIDTH'(1);
        end
    end

    // Flatten counters, port 0 in the LSBs
    always_comb begin
        pkt_cnt = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++)
            pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign pkt_cnt        = '0;
`endif

endmodule

// File: tb/tb_outport_sel_scheduler.sv
// Self-checking bench for outport_sel_scheduler (4 ports, 4-bit counters).
module tb_outport_sel_scheduler;

`ifdef OUTPORT_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_start = 1'b0;
    logic        eop = 1'b0;
    logic [3:0]  out_rdy = '0;
    logic [3:0]  port_en = '0;
    logic [1:0]  mode = '0;
    logic [1:0]  fixed_port = '0;
    logic        cnt_clr = 1'b0;
    logic [1:0]  outport_sel;
    logic        sel_valid;
    logic        busy;
    logic [15:0] pkt_cnt;

    int n_checks = 0;
    int n_pass = 0;

    // reference model state
    bit m_locked = 0;
    bit m_valid = 0;
    int m_sel = 0;
    int m_rr = 0;
    int m_cnt[4] = '{default: 0};

    outport_sel_scheduler #(
        .NUM_PORTS       (4),
        .NUM_PORTS_WIDTH (2),
        .CNT_WIDTH       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pkt_start   (pkt_start),
        .eop         (eop),
        .out_rdy     (out_rdy),
        .port_en     (port_en),
        .mode        (mode),
        .fixed_port  (fixed_port),
        .cnt_clr     (cnt_clr),
        .outport_sel (outport_sel),
        .sel_valid   (sel_valid),
        .busy        (busy),
        .pkt_cnt     (pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit model_pick(input int md, input logic [3:0] en, input logic [3:0] rdy,
                                      input int fx, input int rr, output int p);
        bit f;
        f = 0;
        p = 0;
        if (md == 1) begin
            for (int k = 1; k <= 4; k++) begin
                if (!f && en[(rr + k) % 4] && rdy[(rr + k) % 4]) begin
                    f = 1;
                    p = (rr + k) % 4;
                end
            end
        end else if (md == 2) begin
            for (int q = 0; q < 4; q++) begin
                if (!f && en[q] && rdy[q]) begin
                    f = 1;
                    p = q;
                end
            end
        end else begin
            p = fx;
            f = en[fx];
        end
        return f;
    endfunction

    function automatic logic [15:0] exp_cnt();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[i*4 +: 4] = 4'(m_cnt[i]);
        return r;
    endfunction

    // Advance the model with the current inputs and clock the DUT once.
    task automatic tick();
        bit n_locked, n_valid, f;
        int n_sel, n_rr, p;
        int n_cnt[4];
        n_locked = m_locked;
        n_valid  = m_valid;
        n_sel    = m_sel;
        n_rr     = m_rr;
        n_cnt    = m_cnt;
        if (reset) begin
            n_locked = 0; n_valid = 0; n_sel = 0; n_rr = 0;
            n_cnt = '{default: 0};
        end else begin
            if (!m_locked) begin
                f = model_pick(int'(mode), port_en, out_rdy, int'(fixed_port), m_rr, p);
                if (pkt_start && m_valid) n_locked = 1;
                else if (f) begin n_sel = p; n_valid = 1; end
                else n_valid = 0;
            end else if (eop) begin
                n_rr = m_sel;
                n_cnt[m_sel] = (m_cnt[m_sel] + 1) % 16;
                n_locked = 0;
                n_valid = 0;
            end
            if (cnt_clr) n_cnt = '{default: 0};
            if (!STATS) n_cnt = '{default: 0};
        end
        @(posedge clk);
        #1;
        m_locked = n_locked; m_valid = n_valid; m_sel = n_sel; m_rr = n_rr; m_cnt = n_cnt;
    endtask

    // Wait (bounded) for a valid selection, start a packet, end it on word 'words'.
    task automatic send_pkt(input int words, input bit clr, output int port);
        int guard;
        guard = 0;
        while (sel_valid !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        n_checks++;
        if (sel_valid !== 1'b1) $display("FAIL wait_valid sel_valid=%b want 1", sel_valid);
        else n_pass++;
        port = int'(outport_sel);
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        repeat (words - 2) tick();
        eop = 1'b1;
        cnt_clr = clr;
        tick();
        eop = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (outport_sel !== 2'd0) $display("FAIL reset_sel got %0d want 0", outport_sel); else n_pass++;
        n_checks++;
        if (sel_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", sel_valid); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++;
        if (pkt_cnt !== 16'h0) $display("FAIL reset_cnt got %h want 0", pkt_cnt); else n_pass++;
    endtask

    task automatic test_fixed();
        mode = 2'd0; fixed_port = 2'd2; port_en = 4'b1111; out_rdy = 4'b0000;
        reset = 1'b0;
        tick();
        n_checks++;
        if (outport_sel !== 2'd2) $display("FAIL fixed_sel got %0d want 2", outport_sel); else n_pass++;
        n_checks++;
        if (sel_valid !== 1'b1) $display("FAIL fixed_valid got %b want 1", sel_valid); else n_pass++;
        port_en = 4'b1011;
        tick();
        n_checks++;
        if (sel_valid !== 1'b0) $display("FAIL fixed_disabled_valid got %b want 0", sel_valid); else n_pass++;
        n_checks++;
        if (outport_sel !== 2'd2) $display("FAIL fixed_disabled_hold got %0d want 2", outport_sel); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_seq[4] = '{1, 2, 3, 0};
        int port;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mode = 2'd1; port_en = 4'b1111; out_rdy = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            send_pkt(3, 1'b0, port);
            n_checks++;
            if (port !== exp_seq[i]) $display("FAIL rr_seq%0d got %0d want %0d", i, port, exp_seq[i]); else n_pass++;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL rr_busy_after_eop got %b want 0", busy); else n_pass++;
        end
        n_checks++;
        if (pkt_cnt !== (STATS ? 16'h1111 : 16'h0))
            $display("FAIL rr_counts got %h want %h", pkt_cnt, STATS ? 16'h1111 : 16'h0);
        else n_pass++;
    endtask

    task automatic test_first_ready();
        mode = 2'd2; port_en = 4'b1111; out_rdy = 4'b1100;
        tick();
        tick();
        n_checks++;
        if (outport_sel !== 2'd2 || sel_valid !== 1'b1)
            $display("FAIL fr_sel got %0d/%b want 2/1", outport_sel, sel_valid);
        else n_pass++;
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL fr_busy got %b want 1", busy); else n_pass++;
        out_rdy = 4'b1000;
        tick();
        n_checks++;
        if (outport_sel !== 2'd2) $display("FAIL fr_locked_sel got %0d want 2", outport_sel); else n_pass++;
        eop = 1'b1;
        tick();
        eop = 1'b0;
        n_checks++;
        if (outport_sel !== 2'd2 || busy !== 1'b0 || sel_valid !== 1'b0)
            $display("FAIL fr_after_eop got sel=%0d busy=%b valid=%b want 2/0/0", outport_sel, busy, sel_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (outport_sel !== 2'd3 || sel_valid !== 1'b1)
            $display("FAIL fr_reselect got %0d/%b want 3/1", outport_sel, sel_valid);
        else n_pass++;
    endtask

    task automatic test_midpacket_cfg();
        mode = 2'd0; fixed_port = 2'd1; port_en = 4'b1111; out_rdy = 4'b0000;
        tick();
        n_checks++;
        if (outport_sel !== 2'd1 || sel_valid !== 1'b1)
            $display("FAIL cfg_presel got %0d/%b want 1/1", outport_sel, sel_valid);
        else n_pass++;
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        mode = 2'd2; port_en = 4'b1000; out_rdy = 4'b1000; fixed_port = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (outport_sel !== 2'd1 || busy !== 1'b1)
                $display("FAIL cfg_locked%0d got sel=%0d busy=%b want 1/1", i, outport_sel, busy);
            else n_pass++;
        end
        eop = 1'b1;
        tick();
        eop = 1'b0;
        n_checks++;
        if (outport_sel !== 2'd1 || sel_valid !== 1'b0)
            $display("FAIL cfg_eop1 got %0d/%b want 1/0", outport_sel, sel_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (outport_sel !== 2'd3 || sel_valid !== 1'b1)
            $display("FAIL cfg_eop2 got %0d/%b want 3/1", outport_sel, sel_valid);
        else n_pass++;
    endtask

    task automatic test_counters();
        int port;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mode = 2'd0; fixed_port = 2'd0; port_en = 4'b1111; out_rdy = 4'b0000;
        for (int i = 0; i < 17; i++) send_pkt(2, 1'b0, port);
        n_checks++;
        if (pkt_cnt !== (STATS ? 16'h0001 : 16'h0))
            $display("FAIL cnt_wrap got %h want %h", pkt_cnt, STATS ? 16'h0001 : 16'h0);
        else n_pass++;
        send_pkt(2, 1'b1, port);
        n_checks++;
        if (pkt_cnt !== 16'h0) $display("FAIL cnt_clr_on_eop got %h want 0", pkt_cnt); else n_pass++;
        send_pkt(2, 1'b0, port);
        n_checks++;
        if (pkt_cnt !== (STATS ? 16'h0001 : 16'h0))
            $display("FAIL cnt_after_clr got %h want %h", pkt_cnt, STATS ? 16'h0001 : 16'h0);
        else n_pass++;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_checks++;
        if (pkt_cnt !== 16'h0) $display("FAIL cnt_clr_idle got %h want 0", pkt_cnt); else n_pass++;
    endtask

    task automatic test_reset_midpacket();
        int port;
        mode = 2'd0; fixed_port = 2'd3; port_en = 4'b1111;
        send_pkt(2, 1'b0, port);
        n_checks++;
        if (pkt_cnt !== (STATS ? 16'h1000 : 16'h0))
            $display("FAIL rst_pre_cnt got %h want %h", pkt_cnt, STATS ? 16'h1000 : 16'h0);
        else n_pass++;
        tick();
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || outport_sel !== 2'd3)
            $display("FAIL rst_locked got busy=%b sel=%0d want 1/3", busy, outport_sel);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (outport_sel !== 2'd0 || sel_valid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 16'h0)
            $display("FAIL rst_mid got sel=%0d valid=%b busy=%b cnt=%h want 0/0/0/0",
                     outport_sel, sel_valid, busy, pkt_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(99) == 0);
            pkt_start  = ($urandom_range(9) < 3);
            eop        = ($urandom_range(9) < 3);
            cnt_clr    = ($urandom_range(99) < 3);
            if ($urandom_range(9) < 2) mode = 2'($urandom_range(3));
            port_en    = 4'($urandom);
            out_rdy    = 4'($urandom);
            fixed_port = 2'($urandom_range(3));
            tick();
            n_checks++;
            if (outport_sel !== 2'(m_sel)) $display("FAIL rnd_sel@%0d got %0d want %0d", i, outport_sel, m_sel); else n_pass++;
            n_checks++;
            if (sel_valid !== m_valid) $display("FAIL rnd_valid@%0d got %b want %b", i, sel_valid, m_valid); else n_pass++;
            n_checks++;
            if (busy !== m_locked) $display("FAIL rnd_busy@%0d got %b want %b", i, busy, m_locked); else n_pass++;
            n_checks++;
            if (pkt_cnt !== exp_cnt()) $display("FAIL rnd_cnt@%0d got %h want %h", i, pkt_cnt, exp_cnt()); else n_pass++;
        end
        reset = 1'b0; pkt_start = 1'b0; eop = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_first_ready();
        test_midpacket_cfg();
        test_counters();
        test_reset_midpacket();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
